sr_bank_driver: RTL and testbench
=================================

# sr_bank_driver

Command-side driver for a bank of clocked SR flip-flops. Accepts a target bit vector over a valid/ready handshake, issues one-cycle set/reset pulses only on bits that differ from the bank's current state, then watches the bank's Q feedback until it matches or a timeout expires. It is the initiator for the SR flip-flop bank: it generates S/R so that S=1, R=1 on the same bit never occurs, and it reports completion or failure.

## Interface
Parameters:
- WIDTH, 4, number of SR flip-flops driven (≥1)
- TIMEOUT, 3, max feedback compare cycles in WAIT before error (≥1)

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req_valid  input  1  request present
- req_ready  output  1  block can accept; equals (state==IDLE)
- req_data  input  WIDTH  target state for the bank
- S  output  WIDTH  set pulses to bank, registered
- R  output  WIDTH  reset pulses to bank, registered
- Q_fb  input  WIDTH  current Q of the bank
- busy  output  1  high in DRIVE and WAIT
- done  output  1  one-cycle pulse: bank matches target
- error  output  1  one-cycle pulse: timeout, bank did not match

## Operation
- States: IDLE, DRIVE, WAIT. Reset → IDLE.
- Reset values: S=0, R=0, busy=0, done=0, error=0, req_ready=1, internal counter=0, target register=0.
- IDLE: handshake fires when req_valid & req_ready at a posedge. Capture target=req_data.
  - If req_data==Q_fb at that edge: done=1 for the next cycle, stay IDLE (no S/R activity).
  - Else: S ← req_data & ~Q_fb, R ← ~req_data & Q_fb; go DRIVE.
- DRIVE (exactly one cycle): next edge clears S and R to 0, counter ← 0, go WAIT.
- WAIT: at each edge compare Q_fb with target.
  - Match: done=1 for one cycle, go IDLE.
  - Mismatch and counter==TIMEOUT-1: error=1 for one cycle, go IDLE.
  - Otherwise counter ← counter+1.
- Counter width: clog2(TIMEOUT+1); never wraps (exit at TIMEOUT-1).
- Invariant: (S & R)==0 on every bit in every cycle, including reset and post-reset cycles.
- done and error are never high together; each is high for exactly one cycle per request.
- req_valid ignored outside IDLE; req_data sampled only at the accepting edge.
- Changes on Q_fb during DRIVE are ignored; only WAIT compares.
- No retry: after error the bank is left as-is; the requester re-issues.

## Timing
- Accept at edge k (changing request): S/R valid during cycle k→k+1; S=R=0 from edge k+1; busy high k→k+2 minimum.
- First compare at edge k+2; best-case done high during cycle k+2→k+3; req_ready back high after edge k+2.
- Worst case: error at edge k+1+TIMEOUT, high for one cycle.
- No-change request: done high during k→k+1, req_ready stays 1; back-to-back accepts on consecutive edges are allowed.
- A new request can be accepted on the same edge that done/error is deasserted (first IDLE edge).
- Reset asserted mid-DRIVE/WAIT: S, R, busy, done, error go 0 asynchronously, without waiting for an edge; state IDLE; pending request dropped, no done/error emitted.
- Reset release: first possible accept at first posedge with reset low.

## Test plan
- Set all: Q_fb=0000, request 1111 at edge k, bank model follows → S=1111, R=0000 for one cycle, done pulse at edge k+2, error stays 0.
- Mixed: Q_fb=1010, request 0110 → S=0100, R=1000 for one cycle, never S&R≠0, done at k+2.
- No change: Q_fb=0101, request 0101 → S=R=0, done high the cycle after accept, busy stays 0.
- Timeout: Q_fb held stuck at 0000, request 0001, TIMEOUT=3 → S=0001 one cycle, error pulse at edge k+4, done never high, req_ready high after.
- Reset mid-DRIVE: assert reset while S=1111 → S, R, busy immediately 0, no done/error. After release, request 0011 completes normally.
- Back-to-back: two requests 1100 then 0011 with req_valid held high → second accepted on the first IDLE edge after done, two done pulses, assertion (S&R)==0 throughout.

Source files
------------

// File: rtl/sr_bank_driver.sv
// Command-side driver for a bank of clocked SR flip-flops: pulses S/R only on
// bits that differ from Q feedback, then waits for the bank to match or time out.
module sr_bank_driver #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] R,
   input  logic [WIDTH-1:0] Q_fb,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   target_q, target_d;
   logic [WIDTH-1:0]   s_d, r_d;
   logic               done_d, error_d;
   logic               ready_d, busy_d;

   logic               accept;
   logic               req_same;
   logic               match;
   logic               expired;

   assign accept   = req_valid && (state_q == ST_IDLE);
   assign req_same = (req_data == Q_fb);
   assign match    = (Q_fb == target_q);
   assign expired  = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !req_same) begin
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (match || expired) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values; S and R are disjoint by construction
   always_comb begin
      s_d      = '0;
      r_d      = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      cnt_d    = cnt_q;
      target_d = target_q;
      ready_d  = (state_d == ST_IDLE);
      busy_d   = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               target_d = req_data;
               if (req_same) begin
                  done_d = 1'b1;
               end else begin
                  s_d = req_data & ~Q_fb;
                  r_d = ~req_data & Q_fb;
               end
            end
         end
         ST_DRIVE: begin
            cnt_d = '0;
         end
         ST_WAIT: begin
            if (match) begin
               done_d = 1'b1;
            end else if (expired) begin
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         S         <= '0;
         R         <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
         cnt_q     <= '0;
         target_q  <= '0;
      end else begin
         S         <= s_d;
         R         <= r_d;
         done      <= done_d;
         error     <= error_d;
         busy      <= busy_d;
         req_ready <= ready_d;
         cnt_q     <= cnt_d;
         target_q  <= target_d;
      end
   end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Scoreboard bench for sr_bank_driver: stimulus queues expected S/R pulses and
// done/error responses; a negedge monitor pops and compares them.
module tb_sr_bank_driver;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_data;
   logic [3:0] S;
   logic [3:0] R;
   logic [3:0] Q_fb;
   logic       busy;
   logic       done;
   logic       error;

   logic [3:0] bank;
   logic       follow;
   logic       load;
   logic [3:0] load_val;
   int         cyc;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic is_err;
      int   due;
   } rsp_t;

   rsp_t       rsp_q[$];
   logic [7:0] sr_q[$];

   sr_bank_driver #(.WIDTH(4), .TIMEOUT(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .S         (S),
      .R         (R),
      .Q_fb      (Q_fb),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   assign Q_fb = bank;

   always @(posedge clock) cyc <= cyc + 1;

   // Bank model: follows S/R pulses unless held stuck; load forces a value
   always @(posedge clock) begin
      if (load)        bank <= load_val;
      else if (follow) bank <= (bank & ~R) | S;
   end

   task automatic chk(input string name, input logic ok, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: invariant plus scoreboard pops
   always @(negedge clock) begin
      chk("s_and_r_disjoint", (S & R) == 4'b0, int'(S & R), 0);
      if (done && error) chk("done_error_together", 1'b0, 3, 0);
      if ((S | R) != 4'b0) begin
         if (sr_q.size() == 0) begin
            chk("unexpected_sr_pulse", 1'b0, int'({S, R}), 0);
         end else begin
            logic [7:0] e;
            e = sr_q.pop_front();
            chk("sr_pulse", {S, R} == e, int'({S, R}), int'(e));
         end
      end
      if (done || error) begin
         if (rsp_q.size() == 0) begin
            chk("unexpected_response", 1'b0, int'({done, error}), 0);
         end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            chk("rsp_kind_is_error", error == e.is_err, int'(error), int'(e.is_err));
            chk("rsp_cycle", cyc == e.due, cyc, e.due);
         end
      end
   end

   // Must be called at a negedge; returns at the negedge after the accept edge k
   task automatic send(input logic [3:0] d, input logic [3:0] exp_s, input logic [3:0] exp_r,
                       input logic exp_err, input int lat, input logic push_rsp, output int k);
      int n;
      n = 0;
      k = -1;
      req_valid = 1'b1;
      req_data  = d;
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 1'b0, n, 50);
      end else begin
         k = cyc + 1;
         if ((exp_s | exp_r) != 4'b0) sr_q.push_back({exp_s, exp_r});
         if (push_rsp) rsp_q.push_back('{exp_err, k + lat});
         @(negedge clock);
      end
      req_valid = 1'b0;
   endtask

   task automatic load_bank(input logic [3:0] v);
      load     = 1'b1;
      load_val = v;
      @(negedge clock);
      load = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_expired actual=%0d required=0", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k1, k2;
      cyc       = 0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_data  = 4'b0;
      bank      = 4'b0;
      follow    = 1'b1;
      load      = 1'b0;
      load_val  = 4'b0;
      idle_cycles(2);
      chk("reset_s", S == 4'b0, int'(S), 0);
      chk("reset_r", R == 4'b0, int'(R), 0);
      chk("reset_busy", busy == 1'b0, int'(busy), 0);
      chk("reset_done", done == 1'b0, int'(done), 0);
      chk("reset_error", error == 1'b0, int'(error), 0);
      chk("reset_ready", req_ready == 1'b1, int'(req_ready), 1);
      reset = 1'b0;
      @(negedge clock);

      // Set all
      send(4'b1111, 4'b1111, 4'b0000, 1'b0, 2, 1'b1, k1);
      chk("busy_during_drive", busy == 1'b1, int'(busy), 1);
      chk("ready_low_during_drive", req_ready == 1'b0, int'(req_ready), 0);
      idle_cycles(4);
      chk("bank_all_set", bank == 4'b1111, int'(bank), 'hf);

      // Mixed
      load_bank(4'b1010);
      send(4'b0110, 4'b0100, 4'b1000, 1'b0, 2, 1'b1, k1);
      idle_cycles(4);
      chk("bank_mixed", bank == 4'b0110, int'(bank), 'h6);

      // No change
      load_bank(4'b0101);
      send(4'b0101, 4'b0000, 4'b0000, 1'b0, 0, 1'b1, k1);
      chk("nochange_busy", busy == 1'b0, int'(busy), 0);
      chk("nochange_ready", req_ready == 1'b1, int'(req_ready), 1);
      idle_cycles(2);

      // Timeout with the bank stuck at zero
      follow = 1'b0;
      load_bank(4'b0000);
      send(4'b0001, 4'b0001, 4'b0000, 1'b1, 4, 1'b1, k1);
      idle_cycles(6);
      chk("timeout_ready_after", req_ready == 1'b1, int'(req_ready), 1);
      chk("timeout_busy_after", busy == 1'b0, int'(busy), 0);
      follow = 1'b1;

      // Reset mid-DRIVE: no response is expected for this request
      send(4'b1111, 4'b1111, 4'b0000, 1'b0, 2, 1'b0, k1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_s", S == 4'b0, int'(S), 0);
      chk("rst_async_r", R == 4'b0, int'(R), 0);
      chk("rst_async_busy", busy == 1'b0, int'(busy), 0);
      chk("rst_async_ready", req_ready == 1'b1, int'(req_ready), 1);
      @(negedge clock);
      idle_cycles(1);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_bank_untouched", bank == 4'b0000, int'(bank), 0);
      send(4'b0011, 4'b0011, 4'b0000, 1'b0, 2, 1'b1, k1);
      idle_cycles(4);

      // Back-to-back with req_valid effectively held high
      send(4'b1100, 4'b1100, 4'b0011, 1'b0, 2, 1'b1, k1);
      send(4'b0011, 4'b0011, 4'b1100, 1'b0, 2, 1'b1, k2);
      chk("b2b_accept_first_idle_edge", k2 == k1 + 3, k2 - k1, 3);
      idle_cycles(5);
      chk("bank_b2b_final", bank == 4'b0011, int'(bank), 'h3);

      chk("rsp_queue_drained", rsp_q.size() == 0, rsp_q.size(), 0);
      chk("sr_queue_drained", sr_q.size() == 0, sr_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
